// File: rtl/ser_pkg.sv
// Shared types and helpers for the byte serializer and its round-robin load arbiter.
package ser_pkg;

    localparam int DATA_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } ser_arb_state_t;

    // Never returns less than 1 so the result can always size a vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_arbiter_if.sv
// Requester/serializer bundle for ser_arbiter; slave is the arbiter side, master the producers and serializer.
interface ser_arbiter_if
    import ser_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DFLT
) ();

    localparam int ID_W = clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    ser_load;
    logic [DATA_W-1:0]       ser_data;
    logic [ID_W-1:0]         ser_id;
    logic                    ser_busy;
    logic                    arb_busy;
    logic                    err;

    modport slave (
        input  req,
        input  req_data,
        input  ser_busy,
        output gnt,
        output ser_load,
        output ser_data,
        output ser_id,
        output arb_busy,
        output err
    );

    modport master (
        output req,
        output req_data,
        output ser_busy,
        input  gnt,
        input  ser_load,
        input  ser_data,
        input  ser_id,
        input  arb_busy,
        input  err
    );

endinterface

// File: rtl/ser_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping at N_REQ.
module rr_pick
    import ser_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [ID_W-1:0]  win_idx_o,
    output logic             win_any_o
);

    logic [N_REQ-1:0] win_oh_s;
    logic [ID_W-1:0]  win_idx_s;
    logic             win_any_s;
    logic [ID_W-1:0]  cand_s;

    // Priority scan; k runs 1..N_REQ so the last-granted index is checked last.
    always_comb begin
        win_oh_s  = '0;
        win_idx_s = '0;
        win_any_s = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = ID_W'((int'(ptr_i) + k) % N_REQ);
            if (!win_any_s && req_i[cand_s]) begin
                win_any_s        = 1'b1;
                win_oh_s[cand_s] = 1'b1;
                win_idx_s        = cand_s;
            end else begin
                win_any_s = win_any_s;
            end
        end
    end

    assign win_oh_o  = win_oh_s;
    assign win_idx_o = win_idx_s;
    assign win_any_o = win_any_s;

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin arbiter and load sequencer sharing one byte serializer; one grant per complete busy frame.
// Optional watchdog enabled by defining SER_ARB_TIMEOUT_EN.
module ser_arbiter
    import ser_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DFLT,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         rst,
    ser_arbiter_if.slave bus
);

    localparam int ID_W = clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("ser_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("ser_arbiter: TIMEOUT_CYC must be at least 2");
    end

    ser_arb_state_t    state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              ser_load_q, ser_load_d;
    logic [DATA_W-1:0] ser_data_q, ser_data_d;
    logic [ID_W-1:0]   ser_id_q, ser_id_d;
    logic              arb_busy_q, arb_busy_d;
    logic              timeout_s;

    logic [N_REQ-1:0]  win_oh_s;
    logic [ID_W-1:0]   win_idx_s;
    logic              win_any_s;
    logic [DATA_W-1:0] lane_s [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_s[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh_s),
        .win_idx_o (win_idx_s),
        .win_any_o (win_any_s)
    );

    // FSM next state and registered output values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        ser_load_d = 1'b0;
        ser_data_d = ser_data_q;
        ser_id_d   = ser_id_q;
        case (state_q)
            IDLE: begin
                if (win_any_s) begin
                    gnt_d      = win_oh_s;
                    ser_load_d = 1'b1;
                    ser_data_d = lane_s[win_idx_s];
                    ser_id_d   = win_idx_s;
                    ptr_d      = win_idx_s;
                    state_d    = WAIT_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (timeout_s) begin
                    state_d = IDLE;
                end else if (bus.ser_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (timeout_s) begin
                    state_d = IDLE;
                end else if (!bus.ser_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(N_REQ - 1);
            gnt_q      <= '0;
            ser_load_q <= 1'b0;
            ser_data_q <= '0;
            ser_id_q   <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            ser_load_q <= ser_load_d;
            ser_data_q <= ser_data_d;
            ser_id_q   <= ser_id_d;
            arb_busy_q <= arb_busy_d;
        end
    end

`ifdef SER_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // The counter is 0 in IDLE, so the watchdog can only fire from a wait state.
    always_comb begin
        timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        if (state_q == IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout_s;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_s = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.ser_load = ser_load_q;
    assign bus.ser_data = ser_data_q;
    assign bus.ser_id   = ser_id_q;
    assign bus.arb_busy = arb_busy_q;

endmodule
